pipe_skid_stage: RTL and testbench

- Parametrised pipeline-stage register carrying pc, instr and a retired-instruction tally (total) between CPU stages.
- Successor to the plain per-stage latch: adds valid/ready back-pressure via a 2-entry skid buffer, synchronous flush with NOP-bubble insertion, and a saturating bubble counter for debug.
- Drop-in between IF/ID, ID/EX, EX/MEM and MEM/WB. in_ready is a registered signal, so stall paths do not chain combinationally across stages.

---
 rtl/cpu_pipe_pkg.sv | 28 ++
 rtl/pipe_skid_stage_if.sv | 38 +++
 rtl/pipe_skid_stage_sat_counter.sv | 29 ++
 rtl/pipe_skid_stage.sv | 112 +++++++++++
 tb/tb_pipe_skid_stage.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pipe_pkg                                                         |
// | Shared types and defaults for the CPU pipeline stage registers.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pipe_pkg;

   localparam int          c_pc_w      = 32;
   localparam int          c_instr_w   = 32;
   localparam int          c_cnt_w     = 7;
   localparam int          c_bub_w     = 16;
   localparam logic [31:0] c_nop_instr = 32'h0000_0000;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_t;

   typedef struct packed {
      logic [c_pc_w-1:0]    pc;
      logic [c_instr_w-1:0] instr;
      logic [c_cnt_w-1:0]   total;
   } stage_payload_t;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_skid_stage_if                                                   |
// | Upstream/downstream handshake and payload bundle of one stage.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface pipe_skid_stage_if
   import cpu_pipe_pkg::*;
#(
   parameter int PC_W    = c_pc_w,
   parameter int INSTR_W = c_instr_w,
   parameter int CNT_W   = c_cnt_w,
   parameter int BUB_W   = c_bub_w
);
   logic               in_valid;
   logic               in_ready;
   logic [PC_W-1:0]    in_pc;
   logic [INSTR_W-1:0] in_instr;
   logic [CNT_W-1:0]   in_total;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    out_pc;
   logic [INSTR_W-1:0] out_instr;
   logic [CNT_W-1:0]   out_total;
   logic [BUB_W-1:0]   bubble_cnt;

   modport master (
      output in_valid, in_pc, in_instr, in_total, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, out_total, bubble_cnt
   );

   modport slave (
      input  in_valid, in_pc, in_instr, in_total, flush, out_ready,
      output in_ready, out_valid, out_pc, out_instr, out_total, bubble_cnt
   );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_stage_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter                                                          |
// | Up-counter that sticks at all-ones instead of wrapping.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_en,
   output logic [WIDTH-1:0]      o_count
);
   localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_en && (r_count != '1)) begin
         r_count <= r_count + c_one;
      end
   end

   assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_skid_stage                                                      |
// | Pipeline register with 2-entry skid buffer, flush and bubble count.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_skid_stage
   import cpu_pipe_pkg::*;
#(
   parameter int                 PC_W      = c_pc_w,
   parameter int                 INSTR_W   = c_instr_w,
   parameter int                 CNT_W     = c_cnt_w,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(c_nop_instr),
   parameter int                 BUB_W     = c_bub_w
) (
   input wire logic        clk,
   input wire logic        rst,
   pipe_skid_stage_if.slave bus
);
   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic [CNT_W-1:0]   total;
   } payload_t;

   stage_state_t r_state;
   stage_state_t w_state_nxt;
   payload_t     r_main;
   payload_t     r_skid;
   payload_t     w_in_payload;
   logic         r_in_ready;
   logic         w_in_fire;
   logic         w_out_fire;
   logic         w_out_valid;
   logic         w_load_main_in;
   logic         w_load_main_skid;
   logic         w_load_skid;

   assign w_out_valid  = (r_state != EMPTY);
   assign w_in_fire    = bus.in_valid & r_in_ready;
   assign w_out_fire   = w_out_valid & bus.out_ready;
   assign w_in_payload = '{pc: bus.in_pc, instr: bus.in_instr, total: bus.in_total};

   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_in_fire) begin
               w_state_nxt    = ONE;
               w_load_main_in = 1'b1;
            end
         end
         ONE: begin
            if (w_in_fire && w_out_fire) begin
               w_load_main_in = 1'b1;
            end else if (w_in_fire) begin
               w_state_nxt = FULL;
               w_load_skid = 1'b1;
            end else if (w_out_fire) begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (w_out_fire) begin
               w_state_nxt      = ONE;
               w_load_main_skid = 1'b1;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   // Flush overrides the handshake; an out_fire in the same cycle is simply lost state.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         r_state    <= EMPTY;
         r_in_ready <= 1'b1;
         r_main     <= '0;
         r_skid     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != FULL);
         if (w_load_main_in) begin
            r_main <= w_in_payload;
         end else if (w_load_main_skid) begin
            r_main <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= w_in_payload;
         end
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_pc    = w_out_valid ? r_main.pc    : '0;
   assign bus.out_instr = w_out_valid ? r_main.instr : NOP_INSTR;
   assign bus.out_total = w_out_valid ? r_main.total : '0;

   sat_counter #(
      .WIDTH (BUB_W)
   ) u_bubble_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_en    (bus.out_ready & ~w_out_valid),
      .o_count (bus.bubble_cnt)
   );
endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_skid_stage                                                   |
// | Scenario and randomized checks against a queue-based stage model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipe_skid_stage;
   import cpu_pipe_pkg::*;

   localparam int          TB_BUB = 10;
   localparam int          VEC_W  = 2 + 32 + 32 + 7 + TB_BUB;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [6:0]  total;
   } pl_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   pl_t               m_q[$];
   logic              m_ready;
   logic [TB_BUB-1:0] m_bub;

   pipe_skid_stage_if #(.PC_W(32), .INSTR_W(32), .CNT_W(7), .BUB_W(TB_BUB)) b ();

   pipe_skid_stage #(
      .PC_W      (32),
      .INSTR_W   (32),
      .CNT_W     (7),
      .NOP_INSTR (NOP),
      .BUB_W     (TB_BUB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [VEC_W-1:0] obs_vec();
      return {b.out_valid, b.in_ready, b.out_pc, b.out_instr, b.out_total, b.bubble_cnt};
   endfunction

   // Outputs expected from an ideal 2-deep FIFO: head shown when non-empty.
   function automatic logic [VEC_W-1:0] exp_vec();
      if (m_q.size() == 0) return {1'b0, m_ready, 32'h0, NOP, 7'h0, m_bub};
      return {1'b1, m_ready, m_q[0].pc, m_q[0].instr, m_q[0].total, m_bub};
   endfunction

   task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
      b.in_valid  = v;
      b.in_pc     = pc;
      b.in_instr  = $urandom;
      b.in_total  = 7'($urandom);
      b.out_ready = ordy;
      b.flush     = fl;
   endtask

   task automatic clk_step();
      logic in_fire;
      logic out_fire;
      in_fire  = b.in_valid && m_ready;
      out_fire = (m_q.size() != 0) && b.out_ready;
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_ready = 1'b1;
         m_bub   = '0;
      end else begin
         if (b.out_ready && (m_q.size() == 0) && (m_bub != '1)) m_bub = m_bub + 1'b1;
         if (b.flush) begin
            m_q.delete();
         end else begin
            if (out_fire) void'(m_q.pop_front());
            if (in_fire) m_q.push_back(pl_t'{b.in_pc, b.in_instr, b.in_total});
         end
         m_ready = (m_q.size() < 2);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      clk_step();
      clk_step();
      rst = 1'b0;
      n_checks++;
      if (obs_vec() !== {1'b0, 1'b1, 32'h0, NOP, 7'h0, {TB_BUB{1'b0}}}) begin
         n_fail++;
         $display("FAIL reset_state got %h exp %h", obs_vec(), {1'b0, 1'b1, 32'h0, NOP, 7'h0, {TB_BUB{1'b0}}});
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0);
         clk_step();
      end
      n_checks++;
      if (b.bubble_cnt !== TB_BUB'(5) || b.out_instr !== NOP || b.in_ready !== 1'b1 || b.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle got bub=%0d instr=%h rdy=%b vld=%b exp bub=5 instr=%h rdy=1 vld=0",
                  b.bubble_cnt, b.out_instr, b.in_ready, b.out_valid, NOP);
      end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 5; i++) begin
         drive(i < 4, 32'(4 * i), 1'b1, 1'b0);
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL stream_model cyc%0d got %h exp %h", i, obs_vec(), exp_vec());
         end
         if (i >= 1) begin
            n_checks++;
            if (b.out_valid !== 1'b1 || b.out_pc !== 32'(4 * (i - 1)) || b.in_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL stream_pc cyc%0d got vld=%b pc=%h rdy=%b exp vld=1 pc=%h rdy=1",
                        i, b.out_valid, b.out_pc, b.in_ready, 32'(4 * (i - 1)));
            end
         end
         clk_step();
      end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 32'h10, 1'b0, 1'b0);
      clk_step();
      drive(1'b1, 32'h14, 1'b0, 1'b0);
      clk_step();
      n_checks++;
      if (b.in_ready !== 1'b0 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL bp_full got rdy=%b vec=%h exp rdy=0 vec=%h", b.in_ready, obs_vec(), exp_vec());
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
         n_checks++;
         if ((i < 2 && (b.out_valid !== 1'b1 || b.out_pc !== 32'h10 + 32'(4 * i))) || (i == 2 && b.out_valid !== 1'b0)) begin
            n_fail++;
            $display("FAIL bp_drain cyc%0d got vld=%b pc=%h exp pc=%h", i, b.out_valid, b.out_pc, 32'h10 + 32'(4 * i));
         end
         clk_step();
      end
   endtask

   task automatic test_flush();
      drive(1'b1, 32'h20, 1'b0, 1'b0);
      clk_step();
      drive(1'b1, 32'h24, 1'b0, 1'b0);
      clk_step();
      drive(1'b1, 32'h28, 1'b0, 1'b1);
      clk_step();
      n_checks++;
      if (b.out_valid !== 1'b0 || b.out_instr !== NOP || b.in_ready !== 1'b1 || b.out_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL flush_state got vld=%b instr=%h rdy=%b pc=%h exp vld=0 instr=%h rdy=1 pc=0",
                  b.out_valid, b.out_instr, b.in_ready, b.out_pc, NOP);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h28, 1'b1, 1'b0);
         n_checks++;
         if (b.out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL flush_drop cyc%0d got %h exp %h", i, obs_vec(), exp_vec());
         end
         clk_step();
      end
   endtask

   task automatic test_bubble_sat();
      for (int i = 0; i < (1 << TB_BUB) + 3; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0);
         clk_step();
      end
      n_checks++;
      if (b.bubble_cnt !== {TB_BUB{1'b1}} || m_bub !== {TB_BUB{1'b1}}) begin
         n_fail++;
         $display("FAIL bubble_sat got %h exp %h", b.bubble_cnt, {TB_BUB{1'b1}});
      end
   endtask

   task automatic test_reset_full();
      drive(1'b1, 32'h30, 1'b0, 1'b0);
      clk_step();
      drive(1'b1, 32'h34, 1'b0, 1'b0);
      clk_step();
      rst = 1'b1;
      drive(1'b1, 32'h38, 1'b0, 1'b1);
      clk_step();
      rst = 1'b0;
      n_checks++;
      if (obs_vec() !== {1'b0, 1'b1, 32'h0, NOP, 7'h0, {TB_BUB{1'b0}}}) begin
         n_fail++;
         $display("FAIL reset_full got %h exp %h", obs_vec(), {1'b0, 1'b1, 32'h0, NOP, 7'h0, {TB_BUB{1'b0}}});
      end
      drive(1'b1, 32'h40, 1'b1, 1'b0);
      clk_step();
      n_checks++;
      if (b.out_valid !== 1'b1 || b.out_pc !== 32'h40 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_first got vld=%b pc=%h exp vld=1 pc=00000040", b.out_valid, b.out_pc);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      clk_step();
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom), $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            errs++;
            if (errs <= 10) $display("FAIL random cyc%0d got %h exp %h", i, obs_vec(), exp_vec());
         end
         clk_step();
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      m_ready   = 1'b1;
      m_bub     = '0;
      rst       = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_bubble_sat();
      test_reset_full();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
